eye_centroid_div_seq: RTL and testbench

//  Per-frame sequencer for the single shared serial divider used to produce the pupil centroid.
//  On each rising edge of iFVSYNC it snapshots SUM_S/SUM_SX/SUM_SY, then issues two divisions on the divider:
//  SX/S, then SY/S. It publishes both quotients atomically to the register block as QUOTIENT_SX/QUOTIENT_SY.
//  It also flags divide-by-zero, divider timeout and frame overrun.

---
 rtl/eye_centroid_div_seq_if.sv | 31 +++
 rtl/eye_centroid_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_eye_centroid_div_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eye_centroid_div_seq_if.sv
// Purpose: divider request/response bundle shared by the centroid sequencer and the serial divider.
// Latency: pure wiring, no storage.
// Backpressure: none; the divider answers with a one-cycle done pulse whenever it is ready.
interface eye_centroid_div_seq_if #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 20
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;

    // Sequencer side: issues operands, consumes the result.
    modport master (
        output start,
        output dividend,
        output divisor,
        input  done,
        input  quotient
    );

    // Divider side: consumes operands, returns the result.
    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output done,
        output quotient
    );
endinterface

// File: rtl/eye_centroid_div_seq.sv
// Purpose: per-frame sequencer running SX/S then SY/S on one shared divider; publishes both quotients together.
// Latency: START for X is issued 2 cycles after the vsync rise; oVALID follows the Y done pulse by 1 cycle.
// Backpressure: none; a vsync rise while busy is dropped and flagged, a silent divider is aborted by timeout.
module eye_centroid_div_seq #(
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_SX_WIDTH = 28,
    parameter int SUM_SY_WIDTH = 28,
    parameter int DIV_TIMEOUT  = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    iFVSYNC,
    input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
    input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
    input  logic [SUM_SY_WIDTH-1:0] iSUM_SY,
    eye_centroid_div_seq_if.master  div_if,
    input  logic                    iCLR_ERR,
    output logic [SUM_SX_WIDTH-1:0] oQUOTIENT_SX,
    output logic [SUM_SX_WIDTH-1:0] oQUOTIENT_SY,
    output logic                    oVALID,
    output logic                    oBUSY,
    output logic                    oERR_DIV0,
    output logic                    oERR_TIMEOUT,
    output logic                    oERR_OVERRUN
);

    localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        START_X = 3'd2,
        WAIT_X  = 3'd3,
        START_Y = 3'd4,
        WAIT_Y  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    prev_q, prev_d;
    logic [SUM_S_WIDTH-1:0]  s_q, s_d;
    logic [SUM_SX_WIDTH-1:0] sx_q, sx_d;
    logic [SUM_SY_WIDTH-1:0] sy_q, sy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SUM_SX_WIDTH-1:0] temp_x_q, temp_x_d;
    logic [SUM_SX_WIDTH-1:0] qx_q, qx_d;
    logic [SUM_SX_WIDTH-1:0] qy_q, qy_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic [SUM_SX_WIDTH-1:0] dividend_q, dividend_d;
    logic [SUM_S_WIDTH-1:0]  divisor_q, divisor_d;
    logic                    err_div0_q, err_div0_d;
    logic                    err_to_q, err_to_d;
    logic                    err_ov_q, err_ov_d;
    logic                    rise;

    // Next-state, operand and flag logic; every output is computed here one cycle ahead of its register.
    always_comb begin
        rise       = iFVSYNC & ~prev_q;
        prev_d     = iFVSYNC;
        state_d    = state_q;
        s_d        = s_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        cnt_d      = cnt_q;
        temp_x_d   = temp_x_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        // Clear first so that a set below in the same cycle wins.
        err_div0_d = iCLR_ERR ? 1'b0 : err_div0_q;
        err_to_d   = iCLR_ERR ? 1'b0 : err_to_q;
        err_ov_d   = iCLR_ERR ? 1'b0 : err_ov_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    s_d     = iSUM_S;
                    sx_d    = iSUM_SX;
                    sy_d    = iSUM_SY;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (s_q == '0) begin
                    err_div0_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    start_d    = 1'b1;
                    dividend_d = sx_q;
                    divisor_d  = s_q;
                    state_d    = START_X;
                end
            end
            START_X: begin
                cnt_d   = '0;
                state_d = WAIT_X;
            end
            WAIT_X: begin
                // A done in the timeout cycle still counts as success.
                if (div_if.done) begin
                    temp_x_d   = div_if.quotient;
                    start_d    = 1'b1;
                    dividend_d = SUM_SX_WIDTH'(sy_q);
                    state_d    = START_Y;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START_Y: begin
                cnt_d   = '0;
                state_d = WAIT_Y;
            end
            WAIT_Y: begin
                if (div_if.done) begin
                    qx_d    = temp_x_q;
                    qy_d    = div_if.quotient;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame while a sequence is in progress is dropped, not queued.
        if (rise && (state_q != IDLE)) begin
            err_ov_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; prev resets high so a vsync level held through reset is not an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            prev_q     <= 1'b1;
            s_q        <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            cnt_q      <= '0;
            temp_x_q   <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            err_div0_q <= 1'b0;
            err_to_q   <= 1'b0;
            err_ov_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            s_q        <= s_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            cnt_q      <= cnt_d;
            temp_x_q   <= temp_x_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            err_div0_q <= err_div0_d;
            err_to_q   <= err_to_d;
            err_ov_q   <= err_ov_d;
        end
    end

    assign div_if.start    = start_q;
    assign div_if.dividend = dividend_q;
    assign div_if.divisor  = divisor_q;
    assign oQUOTIENT_SX    = qx_q;
    assign oQUOTIENT_SY    = qy_q;
    assign oVALID          = valid_q;
    assign oBUSY           = busy_q;
    assign oERR_DIV0       = err_div0_q;
    assign oERR_TIMEOUT    = err_to_q;
    assign oERR_OVERRUN    = err_ov_q;

endmodule

// File: tb/tb_eye_centroid_div_seq.sv
// Purpose: directed bench for the centroid divider sequencer with a scoreboard on START operands and published quotients.
// Latency: behavioural divider model answers 10 cycles after each START unless silenced.
// Backpressure: none; the bench drives vsync, clear and reset directly.
module tb_eye_centroid_div_seq;
    localparam int SW  = 20;
    localparam int XW  = 28;
    localparam int YW  = 28;
    localparam int TO  = 16;
    localparam int LAT = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          iFVSYNC = 1'b0;
    logic [SW-1:0] iSUM_S = '0;
    logic [XW-1:0] iSUM_SX = '0;
    logic [YW-1:0] iSUM_SY = '0;
    logic          iCLR_ERR = 1'b0;
    logic [XW-1:0] qx, qy;
    logic          valid, busy, err_div0, err_to, err_ov;

    eye_centroid_div_seq_if #(.DIVIDEND_W(XW), .DIVISOR_W(SW)) dif ();

    eye_centroid_div_seq #(
        .SUM_S_WIDTH(SW), .SUM_SX_WIDTH(XW), .SUM_SY_WIDTH(YW), .DIV_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .iFVSYNC(iFVSYNC),
        .iSUM_S(iSUM_S), .iSUM_SX(iSUM_SX), .iSUM_SY(iSUM_SY),
        .div_if(dif), .iCLR_ERR(iCLR_ERR),
        .oQUOTIENT_SX(qx), .oQUOTIENT_SY(qy), .oVALID(valid), .oBUSY(busy),
        .oERR_DIV0(err_div0), .oERR_TIMEOUT(err_to), .oERR_OVERRUN(err_ov)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Divider model: not reset, so a result in flight at reset still arrives afterwards.
    logic          done_en = 1'b1;
    logic          inj_done = 1'b0;
    logic          mdl_done = 1'b0;
    logic [XW-1:0] mdl_quot = '0;
    logic [XW-1:0] pend_quot = '0;
    logic          pending = 1'b0;
    int            lat_cnt = 0;
    always @(posedge CLK) begin
        mdl_done <= 1'b0;
        if (dif.start) begin
            pending   <= 1'b1;
            lat_cnt   <= LAT;
            pend_quot <= (dif.divisor != '0) ? dif.dividend / XW'(dif.divisor) : '0;
        end else if (pending) begin
            if (lat_cnt <= 1) begin
                pending <= 1'b0;
                if (done_en) begin
                    mdl_done <= 1'b1;
                    mdl_quot <= pend_quot;
                end
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end
    assign dif.done     = mdl_done | inj_done;
    assign dif.quotient = mdl_quot;

    int n_chk = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int valid_cnt = 0;
    int last_start_cyc = 0;
    logic [XW+SW-1:0] exp_start[$];
    logic [2*XW-1:0]  exp_valid[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a START or publishes quotients.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dif.start) begin
                start_cnt++;
                last_start_cyc = cyc;
                if (exp_start.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_start: got dividend %0d divisor %0d, none expected", dif.dividend, dif.divisor);
                end else begin
                    chk("start_operands", {dif.dividend, dif.divisor}, exp_start.pop_front());
                end
            end
            if (valid) begin
                valid_cnt++;
                if (exp_valid.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got qx %0d qy %0d, none expected", qx, qy);
                end else begin
                    chk("published_quotients", {qx, qy}, exp_valid.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame(input int s, input int sx, input int sy);
        iSUM_S  = SW'(s);
        iSUM_SX = XW'(sx);
        iSUM_SY = YW'(sy);
        iFVSYNC = 1'b1;
        tick();
        iFVSYNC = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk("idle_reached", busy, 0);
    endtask

    task automatic clear_errs();
        iCLR_ERR = 1'b1;
        tick();
        iCLR_ERR = 1'b0;
    endtask

    task automatic push_start(input int dvd, input int dvs);
        exp_start.push_back({XW'(dvd), SW'(dvs)});
    endtask

    task automatic push_valid(input int x, input int y);
        exp_valid.push_back({XW'(x), XW'(y)});
    endtask

    int sc0, vc0;

    initial begin
        repeat (3) tick();
        chk("reset_qx", qx, 0);
        chk("reset_qy", qy, 0);
        chk("reset_flags", {valid, busy, err_div0, err_to, err_ov, dif.start}, 0);
        RST = 1'b0;
        repeat (2) tick();

        // Nominal frame.
        sc0 = start_cnt; vc0 = valid_cnt;
        push_start(32000, 100); push_start(24000, 100); push_valid(320, 240);
        frame(100, 32000, 24000);
        chk("busy_after_rise", busy, 1);
        wait_idle(100);
        tick();
        chk("nominal_qx", qx, 320);
        chk("nominal_qy", qy, 240);
        chk("nominal_valid_count", valid_cnt - vc0, 1);
        chk("nominal_start_count", start_cnt - sc0, 2);
        chk("nominal_no_errors", {err_div0, err_to, err_ov}, 0);

        // Divide by zero.
        sc0 = start_cnt; vc0 = valid_cnt;
        frame(0, 5, 5);
        wait_idle(20);
        tick();
        chk("div0_flag", err_div0, 1);
        chk("div0_qx_kept", qx, 320);
        chk("div0_qy_kept", qy, 240);
        chk("div0_no_start", start_cnt - sc0, 0);
        chk("div0_no_valid", valid_cnt - vc0, 0);
        clear_errs();
        chk("div0_cleared", err_div0, 0);

        // Overrun during WAIT_Y.
        sc0 = start_cnt; vc0 = valid_cnt;
        push_start(1000, 10); push_start(500, 10); push_valid(100, 50);
        frame(10, 1000, 500);
        for (int i = 0; i < 60 && start_cnt < sc0 + 2; i++) tick();
        chk("ov_second_start_seen", start_cnt - sc0, 2);
        iFVSYNC = 1'b1;
        tick();
        iFVSYNC = 1'b0;
        wait_idle(60);
        repeat (5) tick();
        chk("ov_flag", err_ov, 1);
        chk("ov_single_valid", valid_cnt - vc0, 1);
        chk("ov_no_third_start", start_cnt - sc0, 2);
        chk("ov_qx", qx, 100);
        chk("ov_qy", qy, 50);
        clear_errs();
        chk("ov_cleared", err_ov, 0);

        // Timeout: silent divider.
        sc0 = start_cnt; vc0 = valid_cnt;
        done_en = 1'b0;
        push_start(70, 7);
        frame(7, 70, 0);
        for (int i = 0; i < 80 && !err_to; i++) tick();
        chk("timeout_flag", err_to, 1);
        chk("timeout_latency", cyc - last_start_cyc, 17);
        chk("timeout_not_busy", busy, 0);
        chk("timeout_qx_kept", qx, 100);
        chk("timeout_qy_kept", qy, 50);
        chk("timeout_no_valid", valid_cnt - vc0, 0);
        // Late done in IDLE must be ignored.
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) tick();
        chk("late_done_no_valid", valid_cnt - vc0, 0);
        chk("late_done_not_busy", busy, 0);
        chk("late_done_qx_kept", qx, 100);
        // Next frame runs normally.
        done_en = 1'b1;
        push_start(40, 4); push_start(8, 4); push_valid(10, 2);
        frame(4, 40, 8);
        wait_idle(100);
        tick();
        chk("post_timeout_qx", qx, 10);
        chk("post_timeout_qy", qy, 2);
        clear_errs();
        chk("timeout_cleared", err_to, 0);

        // Clear racing the timeout.
        sc0 = start_cnt;
        done_en = 1'b0;
        push_start(70, 7);
        frame(7, 70, 0);
        for (int i = 0; i < 20 && start_cnt == sc0; i++) tick();
        for (int i = 0; i < 40 && cyc < last_start_cyc + 16; i++) tick();
        chk("race_not_yet_set", err_to, 0);
        iCLR_ERR = 1'b1;
        tick();
        chk("race_set_wins", err_to, 1);
        tick();
        iCLR_ERR = 1'b0;
        chk("race_clear_alone", err_to, 0);
        done_en = 1'b1;
        repeat (2) tick();

        // Reset during WAIT_X with vsync held high.
        sc0 = start_cnt; vc0 = valid_cnt;
        push_start(50, 5);
        iSUM_S = SW'(5); iSUM_SX = XW'(50); iSUM_SY = '0;
        iFVSYNC = 1'b1;
        tick();
        for (int i = 0; i < 20 && start_cnt == sc0; i++) tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_qx", qx, 0);
        chk("rst_qy", qy, 0);
        chk("rst_flags", {valid, busy, err_div0, err_to, err_ov, dif.start}, 0);
        repeat (20) tick();
        chk("rst_held_vsync_no_start", start_cnt - sc0, 1);
        chk("rst_inflight_done_ignored", valid_cnt - vc0, 0);
        chk("rst_held_vsync_idle", busy, 0);
        iFVSYNC = 1'b0;
        tick();
        push_start(9, 2); push_start(3, 2); push_valid(4, 1);
        frame(2, 9, 3);
        wait_idle(100);
        tick();
        chk("post_rst_qx", qx, 4);
        chk("post_rst_qy", qy, 1);
        chk("post_rst_valid_count", valid_cnt - vc0, 1);

        repeat (3) tick();
        chk("start_queue_drained", exp_start.size(), 0);
        chk("valid_queue_drained", exp_valid.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
